// File: rtl/bus_arbiter_if.sv
// Bundle of the shared bus and the three requester ports served by bus_arbiter.
// The master modport is the arbiter's view; the slave modport is the view of the
// environment (the bus and the requesters).
interface bus_arbiter_if;
  logic        o_bus_rw;
  logic        o_bus_request;
  logic        i_bus_ready;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic [31:0] i_bus_rdata;

  logic        i_pa_rw, i_pa_request, o_pa_ready;
  logic [31:0] i_pa_address, i_pa_wdata, o_pa_rdata;
  logic        i_pb_rw, i_pb_request, o_pb_ready;
  logic [31:0] i_pb_address, i_pb_wdata, o_pb_rdata;
  logic        i_pc_rw, i_pc_request, o_pc_ready;
  logic [31:0] i_pc_address, i_pc_wdata, o_pc_rdata;

  logic        o_timeout;
  logic [7:0]  o_timeout_count;

  modport master (
    output o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
    input  i_bus_ready, i_bus_rdata,
    input  i_pa_rw, i_pa_request, i_pa_address, i_pa_wdata,
    output o_pa_ready, o_pa_rdata,
    input  i_pb_rw, i_pb_request, i_pb_address, i_pb_wdata,
    output o_pb_ready, o_pb_rdata,
    input  i_pc_rw, i_pc_request, i_pc_address, i_pc_wdata,
    output o_pc_ready, o_pc_rdata,
    output o_timeout, o_timeout_count
  );

  modport slave (
    input  o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
    output i_bus_ready, i_bus_rdata,
    output i_pa_rw, i_pa_request, i_pa_address, i_pa_wdata,
    input  o_pa_ready, o_pa_rdata,
    output i_pb_rw, i_pb_request, i_pb_address, i_pb_wdata,
    input  o_pb_ready, o_pb_rdata,
    output i_pc_rw, i_pc_request, i_pc_address, i_pc_wdata,
    input  o_pc_ready, o_pc_rdata,
    input  o_timeout, o_timeout_count
  );
endinterface

// File: rtl/bus_arbiter.sv
// Three-port arbiter for a single shared bus. One transfer at a time goes
// through IDLE -> ACTIVE -> RELEASE; the winning request is latched on grant so
// the bus is stable for the whole ACTIVE phase. A watchdog aborts a transfer
// that sees no bus ready within TIMEOUT cycles (0 disables it).
module bus_arbiter #(
  parameter int          ROUND_ROBIN = 1,
  parameter int          TIMEOUT     = 1024,
  parameter logic [31:0] ABORT_DATA  = 32'h0000_0000
) (
  input  logic          i_clock,
  input  logic          i_reset,
  bus_arbiter_if.master bus
);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] PA = 2'd0;
  localparam logic [1:0] PB = 2'd1;
  localparam logic [1:0] PC = 2'd2;

  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      g_q, g_d;
  logic [1:0]      l_q, l_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      tcnt_q, tcnt_d;
  logic            bus_rw_q, bus_rw_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;

  logic [2:0]      req_w, rw_w, ready_w;
  logic [1:0]      win, c1, c2;
  logic            win_vld, expire_w, abort_w, bus_req_w;

  function automatic logic [1:0] succ(input logic [1:0] p);
    return (p == PC) ? PA : p + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] p);
    case (p)
      PA:      return 3'b001;
      PB:      return 3'b010;
      PC:      return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic sel1(input logic [1:0] p, input logic [2:0] v);
    return |(onehot(p) & v);
  endfunction

  function automatic logic [31:0] sel32(input logic [1:0] p, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c);
    case (p)
      PB:      return b;
      PC:      return c;
      default: return a;
    endcase
  endfunction

  assign req_w    = {bus.i_pc_request, bus.i_pb_request, bus.i_pa_request};
  assign rw_w     = {bus.i_pc_rw, bus.i_pb_rw, bus.i_pa_rw};
  assign expire_w = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));

  // Pick the next port to serve: rotating from the last-served port, or fixed pa > pb > pc.
  always_comb begin
    c1      = succ(l_q);
    c2      = succ(c1);
    win_vld = |req_w;
    win     = PA;
    if (ROUND_ROBIN != 0) begin
      if (sel1(c1, req_w))      win = c1;
      else if (sel1(c2, req_w)) win = c2;
      else                      win = l_q;
    end else begin
      if (req_w[0])      win = PA;
      else if (req_w[1]) win = PB;
      else               win = PC;
    end
  end

  // Transfer sequencing, watchdog and completion/abort handshakes.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    l_d         = l_q;
    wd_d        = wd_q;
    tcnt_d      = tcnt_q;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    ready_w     = 3'b000;
    abort_w     = 1'b0;
    bus_req_w   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          g_d         = win;
          l_d         = win;
          wd_d        = '0;
          bus_rw_d    = sel1(win, rw_w);
          bus_addr_d  = sel32(win, bus.i_pa_address, bus.i_pb_address, bus.i_pc_address);
          bus_wdata_d = sel32(win, bus.i_pa_wdata, bus.i_pb_wdata, bus.i_pc_wdata);
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        bus_req_w = 1'b1;
        if (bus.i_bus_ready) begin
          ready_w = onehot(g_q);
          state_d = RELEASE;
        end else if (expire_w) begin
          ready_w = onehot(g_q);
          abort_w = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          state_d = RELEASE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      RELEASE: begin
        if (!sel1(g_q, req_w)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched bus registers; reset abandons any transfer in flight.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      g_q         <= PA;
      l_q         <= PC;
      wd_q        <= '0;
      tcnt_q      <= 8'd0;
      bus_rw_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      l_q         <= l_d;
      wd_q        <= wd_d;
      tcnt_q      <= tcnt_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign bus.o_bus_request   = bus_req_w;
  assign bus.o_bus_rw        = bus_rw_q;
  assign bus.o_bus_address   = bus_addr_q;
  assign bus.o_bus_wdata     = bus_wdata_q;
  assign bus.o_timeout       = abort_w;
  // The incremented count is already visible in the abort cycle itself.
  assign bus.o_timeout_count = tcnt_d;

  assign bus.o_pa_ready = ready_w[0];
  assign bus.o_pb_ready = ready_w[1];
  assign bus.o_pc_ready = ready_w[2];
  assign bus.o_pa_rdata = (abort_w && ready_w[0]) ? ABORT_DATA : bus.i_bus_rdata;
  assign bus.o_pb_rdata = (abort_w && ready_w[1]) ? ABORT_DATA : bus.i_bus_rdata;
  assign bus.o_pc_rdata = (abort_w && ready_w[2]) ? ABORT_DATA : bus.i_bus_rdata;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a rotating-priority instance and a
// fixed-priority instance, both with a 16-cycle watchdog.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  bus_arbiter_if ifa ();
  bus_arbiter_if ifb ();

  bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(16), .ABORT_DATA(32'hDEAD_BEEF)) dut_rr (
    .i_clock(clk), .i_reset(rst), .bus(ifa));
  bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(16), .ABORT_DATA(32'hDEAD_BEEF)) dut_fp (
    .i_clock(clk), .i_reset(rst), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "bench timeout");
  end

  function automatic logic [2:0] rdy_a();
    return {ifa.o_pc_ready, ifa.o_pb_ready, ifa.o_pa_ready};
  endfunction

  function automatic logic [2:0] rdy_b();
    return {ifb.o_pc_ready, ifb.o_pb_ready, ifb.o_pa_ready};
  endfunction

  task automatic clear_inputs();
    ifa.i_bus_ready = 0; ifa.i_bus_rdata = 0;
    ifa.i_pa_rw = 0; ifa.i_pa_request = 0; ifa.i_pa_address = 0; ifa.i_pa_wdata = 0;
    ifa.i_pb_rw = 0; ifa.i_pb_request = 0; ifa.i_pb_address = 0; ifa.i_pb_wdata = 0;
    ifa.i_pc_rw = 0; ifa.i_pc_request = 0; ifa.i_pc_address = 0; ifa.i_pc_wdata = 0;
    ifb.i_bus_ready = 0; ifb.i_bus_rdata = 0;
    ifb.i_pa_rw = 0; ifb.i_pa_request = 0; ifb.i_pa_address = 0; ifb.i_pa_wdata = 0;
    ifb.i_pb_rw = 0; ifb.i_pb_request = 0; ifb.i_pb_address = 0; ifb.i_pb_wdata = 0;
    ifb.i_pc_rw = 0; ifb.i_pc_request = 0; ifb.i_pc_address = 0; ifb.i_pc_wdata = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (ifa.o_bus_request !== 1'b0) $display("FAIL rst_request got %b want 0", ifa.o_bus_request); else n_pass++;
    n_checks++; if (ifa.o_bus_rw !== 1'b0) $display("FAIL rst_rw got %b want 0", ifa.o_bus_rw); else n_pass++;
    n_checks++; if (ifa.o_bus_address !== 32'd0) $display("FAIL rst_address got %h want 0", ifa.o_bus_address); else n_pass++;
    n_checks++; if (ifa.o_bus_wdata !== 32'd0) $display("FAIL rst_wdata got %h want 0", ifa.o_bus_wdata); else n_pass++;
    n_checks++; if (ifa.o_timeout !== 1'b0) $display("FAIL rst_timeout got %b want 0", ifa.o_timeout); else n_pass++;
    n_checks++; if (ifa.o_timeout_count !== 8'd0) $display("FAIL rst_tcount got %0d want 0", ifa.o_timeout_count); else n_pass++;
    n_checks++; if (rdy_a() !== 3'b000) $display("FAIL rst_ready got %b want 000", rdy_a()); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_seq [4];
    logic [2:0] r;
    int         last_cyc;
    logic       found;
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    last_cyc = 0;
    ifa.i_bus_ready = 1; ifa.i_bus_rdata = 32'hA5A5_0001;
    ifa.i_pa_address = 32'h100; ifa.i_pb_address = 32'h200; ifa.i_pc_address = 32'h300;
    ifa.i_pa_request = 1; ifa.i_pb_request = 1; ifa.i_pc_request = 1;
    for (int k = 0; k < 4; k++) begin
      found = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (rdy_a() !== 3'b000) begin found = 1; break; end
      end
      r = rdy_a();
      n_checks++; if (!found || r !== exp_seq[k]) $display("FAIL rr_grant%0d got %b want %b", k, r, exp_seq[k]); else n_pass++;
      if (k == 0) begin
        n_checks++; if (ifa.o_bus_address !== 32'h100) $display("FAIL rr_address got %h want 00000100", ifa.o_bus_address); else n_pass++;
        n_checks++; if (ifa.o_pa_rdata !== 32'hA5A5_0001) $display("FAIL rr_rdata got %h want a5a50001", ifa.o_pa_rdata); else n_pass++;
      end else begin
        n_checks++; if (cyc - last_cyc !== 3) $display("FAIL rr_spacing%0d got %0d want 3", k, cyc - last_cyc); else n_pass++;
      end
      last_cyc = cyc;
      @(posedge clk); #1;
      if (k == 3) begin
        ifa.i_pa_request = 0; ifa.i_pb_request = 0; ifa.i_pc_request = 0;
      end else begin
        if (r[0]) ifa.i_pa_request = 0;
        if (r[1]) ifa.i_pb_request = 0;
        if (r[2]) ifa.i_pc_request = 0;
      end
      @(posedge clk); #1;
      if (k < 3) begin ifa.i_pa_request = 1; ifa.i_pb_request = 1; ifa.i_pc_request = 1; end
    end
    ifa.i_bus_ready = 0;
    @(negedge clk);
    n_checks++; if (ifa.o_bus_request !== 1'b0) $display("FAIL rr_idle_request got %b want 0", ifa.o_bus_request); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_ready();
    int bad;
    bad = 0;
    ifa.i_bus_ready = 1;
    repeat (3) begin
      @(negedge clk);
      if (rdy_a() !== 3'b000 || ifa.o_bus_request !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL idle_ready got %0d bad cycles want 0", bad); else n_pass++;
    @(posedge clk); #1 ifa.i_bus_ready = 0;
  endtask

  task automatic test_hold_latch();
    ifa.i_pb_rw = 1; ifa.i_pb_address = 32'h0000_1000; ifa.i_pb_wdata = 32'hCAFE_F00D; ifa.i_pb_request = 1;
    @(posedge clk); #1;
    ifa.i_pb_address = 32'h0; ifa.i_pb_wdata = 32'h0; ifa.i_pb_rw = 0;
    @(negedge clk);
    n_checks++; if (ifa.o_bus_request !== 1'b1) $display("FAIL hold_request got %b want 1", ifa.o_bus_request); else n_pass++;
    n_checks++; if (ifa.o_bus_address !== 32'h0000_1000) $display("FAIL hold_address got %h want 00001000", ifa.o_bus_address); else n_pass++;
    n_checks++; if (ifa.o_bus_wdata !== 32'hCAFE_F00D) $display("FAIL hold_wdata got %h want cafef00d", ifa.o_bus_wdata); else n_pass++;
    n_checks++; if (ifa.o_bus_rw !== 1'b1) $display("FAIL hold_rw got %b want 1", ifa.o_bus_rw); else n_pass++;
    @(posedge clk); #1 ifa.i_bus_ready = 1; ifa.i_bus_rdata = 32'h0BAD_C0DE;
    @(negedge clk);
    n_checks++; if (rdy_a() !== 3'b010) $display("FAIL hold_ready got %b want 010", rdy_a()); else n_pass++;
    n_checks++; if (ifa.o_pb_rdata !== 32'h0BAD_C0DE) $display("FAIL hold_rdata got %h want 0badc0de", ifa.o_pb_rdata); else n_pass++;
    n_checks++; if (ifa.o_bus_address !== 32'h0000_1000) $display("FAIL hold_address2 got %h want 00001000", ifa.o_bus_address); else n_pass++;
    @(posedge clk); #1 ifa.i_bus_ready = 0; ifa.i_pb_request = 0;
    @(negedge clk);
    n_checks++; if (ifa.o_bus_request !== 1'b0) $display("FAIL hold_release got %b want 0", ifa.o_bus_request); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    ifa.i_pa_rw = 0; ifa.i_pa_address = 32'h40; ifa.i_pa_request = 1;
    ifa.i_bus_ready = 0; ifa.i_bus_rdata = 32'h1111_2222;
    @(posedge clk); #1 ifa.i_pa_request = 0;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (rdy_a() !== 3'b000 || ifa.o_timeout !== 1'b0 || ifa.o_bus_request !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL to_wait got %0d bad cycles want 0", bad); else n_pass++;
    @(negedge clk);
    n_checks++; if (rdy_a() !== 3'b001) $display("FAIL to_ready got %b want 001", rdy_a()); else n_pass++;
    n_checks++; if (ifa.o_pa_rdata !== 32'hDEAD_BEEF) $display("FAIL to_rdata got %h want deadbeef", ifa.o_pa_rdata); else n_pass++;
    n_checks++; if (ifa.o_timeout !== 1'b1) $display("FAIL to_pulse got %b want 1", ifa.o_timeout); else n_pass++;
    n_checks++; if (ifa.o_timeout_count !== 8'd1) $display("FAIL to_count got %0d want 1", ifa.o_timeout_count); else n_pass++;
    n_checks++; if (ifa.o_pb_rdata !== 32'h1111_2222) $display("FAIL to_other_rdata got %h want 11112222", ifa.o_pb_rdata); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (ifa.o_bus_request !== 1'b0) $display("FAIL to_after_request got %b want 0", ifa.o_bus_request); else n_pass++;
    n_checks++; if (ifa.o_timeout !== 1'b0) $display("FAIL to_after_pulse got %b want 0", ifa.o_timeout); else n_pass++;
    n_checks++; if (ifa.o_timeout_count !== 8'd1) $display("FAIL to_after_count got %0d want 1", ifa.o_timeout_count); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_ready_at_expiry();
    int bad;
    bad = 0;
    ifa.i_pc_rw = 1; ifa.i_pc_address = 32'h80; ifa.i_pc_request = 1; ifa.i_bus_ready = 0;
    @(posedge clk); #1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (rdy_a() !== 3'b000 || ifa.o_timeout !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL exp_wait got %0d bad cycles want 0", bad); else n_pass++;
    @(posedge clk); #1 ifa.i_bus_ready = 1; ifa.i_bus_rdata = 32'h1234_5678;
    @(negedge clk);
    n_checks++; if (rdy_a() !== 3'b100) $display("FAIL exp_ready got %b want 100", rdy_a()); else n_pass++;
    n_checks++; if (ifa.o_pc_rdata !== 32'h1234_5678) $display("FAIL exp_rdata got %h want 12345678", ifa.o_pc_rdata); else n_pass++;
    n_checks++; if (ifa.o_timeout !== 1'b0) $display("FAIL exp_pulse got %b want 0", ifa.o_timeout); else n_pass++;
    n_checks++; if (ifa.o_timeout_count !== 8'd1) $display("FAIL exp_count got %0d want 1", ifa.o_timeout_count); else n_pass++;
    @(posedge clk); #1 ifa.i_bus_ready = 0; ifa.i_pc_request = 0;
    n_checks++; if (ifa.o_bus_request !== 1'b0) $display("FAIL exp_release got %b want 0", ifa.o_bus_request); else n_pass++;
    n_checks++; if (ifa.o_timeout_count !== 8'd1) $display("FAIL exp_count2 got %0d want 1", ifa.o_timeout_count); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_priority();
    logic found;
    ifb.i_bus_ready = 1; ifb.i_pb_request = 1; ifb.i_pc_request = 1;
    for (int k = 0; k < 3; k++) begin
      found = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (rdy_b() !== 3'b000) begin found = 1; break; end
      end
      n_checks++; if (!found || rdy_b() !== 3'b010) $display("FAIL fp_grant%0d got %b want 010", k, rdy_b()); else n_pass++;
      @(posedge clk); #1 ifb.i_pb_request = 0;
      if (k == 2) ifb.i_pc_request = 0;
      @(posedge clk); #1;
      if (k < 2) ifb.i_pb_request = 1;
    end
    ifb.i_bus_ready = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic found;
    ifa.i_pb_request = 1; ifa.i_bus_ready = 0;
    @(posedge clk); #1;
    ifa.i_pb_request = 0; ifa.i_pa_request = 1; ifa.i_pc_request = 1;
    @(negedge clk);
    n_checks++; if (ifa.o_bus_request !== 1'b1) $display("FAIL rm_active got %b want 1", ifa.o_bus_request); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (ifa.o_bus_request !== 1'b0) $display("FAIL rm_async_drop got %b want 0", ifa.o_bus_request); else n_pass++;
    ifa.i_bus_ready = 1;
    #1;
    n_checks++; if (rdy_a() !== 3'b000) $display("FAIL rm_no_ready got %b want 000", rdy_a()); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    found = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rdy_a() !== 3'b000) begin found = 1; break; end
    end
    n_checks++; if (!found || rdy_a() !== 3'b001) $display("FAIL rm_first_grant got %b want 001", rdy_a()); else n_pass++;
    @(posedge clk); #1;
    ifa.i_pa_request = 0; ifa.i_pc_request = 0; ifa.i_bus_ready = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_idle_ready();
    test_hold_latch();
    test_timeout();
    test_ready_at_expiry();
    test_fixed_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
